regfile_sequencer: RTL and testbench

//  Command-driven initiator for the 2-read/1-write register file. It accepts one
//  ALU command at a time via valid/ready, reads two operands, computes a result
//  and writes it back. Sits between the test/control front end and the register

---
 rtl/regfile_sequencer.sv | 163 ++++++++++++++++
 tb/tb_regfile_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for a 2-read/1-write register file: IDLE -> READ -> EXEC -> WB.
// Optional condition flags (flag_z/flag_n/flag_c) are built when REGSEQ_FLAGS_EN is defined.
module regfile_sequencer #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic [AW-1:0] rf_rdAddrA,
    input  logic [DW-1:0] rf_rdDataA,
    output logic [AW-1:0] rf_rdAddrB,
    input  logic [DW-1:0] rf_rdDataB,
    output logic          rf_write,
    output logic [AW-1:0] rf_wrAddr,
    output logic [DW-1:0] rf_wrData,
    output logic          done_valid,
    output logic [DW-1:0] done_data
`ifdef REGSEQ_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_c
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t          state_reg, state_next;
    logic [2:0]      op_reg;
    logic [AW-1:0]   rd_reg;
    logic [AW-1:0]   rs1_reg;
    logic [AW-1:0]   rs2_reg;
    logic [DW-1:0]   imm_reg;
    logic [DW-1:0]   opa_reg;
    logic [DW-1:0]   opb_reg;
    logic [DW-1:0]   result_reg;
    logic [DW:0]     alu_next;
    logic            accept;

    assign accept = cmd_valid && (state_reg == S_IDLE);

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        rf_write   = 1'b0;
        done_valid = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = S_READ;
                end
            end
            S_READ: state_next = S_EXEC;
            S_EXEC: state_next = S_WB;
            S_WB: begin
                rf_write   = 1'b1;
                done_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bit DW carries the unsigned carry (ADD/ADDI) or borrow (SUB); zero otherwise.
    always_comb begin
        alu_next = '0;
        case (op_reg)
            OP_ADD:  alu_next = {1'b0, opa_reg} + {1'b0, opb_reg};
            OP_SUB:  alu_next = {1'b0, opa_reg} - {1'b0, opb_reg};
            OP_AND:  alu_next = {1'b0, opa_reg & opb_reg};
            OP_OR:   alu_next = {1'b0, opa_reg | opb_reg};
            OP_XOR:  alu_next = {1'b0, opa_reg ^ opb_reg};
            OP_SLT:  alu_next = {{DW{1'b0}}, ($signed(opa_reg) < $signed(opb_reg))};
            OP_LI:   alu_next = {1'b0, imm_reg};
            OP_ADDI: alu_next = {1'b0, opa_reg} + {1'b0, imm_reg};
            default: alu_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            rd_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= cmd_op;
                rd_reg  <= cmd_rd;
                rs1_reg <= cmd_rs1;
                rs2_reg <= cmd_rs2;
                imm_reg <= cmd_imm;
            end
            if (state_reg == S_READ) begin
                opa_reg <= rf_rdDataA;
                opb_reg <= rf_rdDataB;
            end
            if (state_reg == S_EXEC) begin
                result_reg <= alu_next[DW-1:0];
            end
        end
    end

`ifdef REGSEQ_FLAGS_EN
    logic carry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            if (state_reg == S_EXEC) begin
                carry_reg <= alu_next[DW];
            end
            if (state_reg == S_WB) begin
                flag_z <= (result_reg == '0);
                flag_n <= result_reg[DW-1];
                flag_c <= carry_reg;
            end
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_next[DW];
`endif

    assign rf_rdAddrA = rs1_reg;
    assign rf_rdAddrB = rs2_reg;
    assign rf_wrAddr  = rd_reg;
    assign rf_wrData  = result_reg;
    assign done_data  = result_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural regfile + cycle model, per-cycle compare, directed ALU tests.
// Flag checks are compiled in when REGSEQ_FLAGS_EN is defined.
module tb_regfile_sequencer;

    localparam int DW = 16;
    localparam int AW = 5;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SLT = 3'd5, LI = 3'd6, ADDI = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic [AW-1:0] rf_rdAddrA, rf_rdAddrB, rf_wrAddr;
    logic [DW-1:0] rf_rdDataA, rf_rdDataB, rf_wrData, done_data;
    logic          rf_write, done_valid;
`ifdef REGSEQ_FLAGS_EN
    logic          flag_z, flag_n, flag_c;
`endif

    always #5 clk = ~clk;

    regfile_sequencer #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rf_rdAddrA(rf_rdAddrA), .rf_rdDataA(rf_rdDataA),
        .rf_rdAddrB(rf_rdAddrB), .rf_rdDataB(rf_rdDataB),
        .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
        .done_valid(done_valid), .done_data(done_data)
`ifdef REGSEQ_FLAGS_EN
        , .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
`endif
    );

    // Register file the sequencer drives: combinational reads, write on the clock edge.
    logic [DW-1:0] rf [32];
    assign rf_rdDataA = rf[rf_rdAddrA];
    assign rf_rdDataB = rf[rf_rdAddrB];
    always @(posedge clk) if (rf_write) rf[rf_wrAddr] <= rf_wrData;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc = 0;
    bit pend = 1'b0;
    int wb_edge = 0;
    int acc_count = 0;
    int last_acc = 0;
    int obs_wb_cyc = -1;
    int m_rd, m_rs1, m_rs2, m_res;
    bit m_c;
    bit mz = 1'b0, mn = 1'b0, mc = 1'b0;
    int mrf [32];

    function automatic int sx(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic void alu(input int op, input int a, input int b, input int imm,
                                output int r, output bit c);
        c = 1'b0;
        r = 0;
        case (op)
            0: begin r = a + b;   c = (r > 65535); end
            1: begin r = a - b;   c = (a < b);     end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sx(a) < sx(b)) ? 1 : 0;
            6: r = imm;
            7: begin r = a + imm; c = (r > 65535); end
            default: r = 0;
        endcase
        r = r & 32'hFFFF;
    endfunction

    // A command accepted at edge n is written back at edge n+3; next accept no earlier than n+4.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend = 1'b0;
            mz = 1'b0; mn = 1'b0; mc = 1'b0;
        end else if (pend) begin
            if (cyc == wb_edge) begin
                mrf[m_rd] = m_res;
                mz = (m_res == 0);
                mn = ((m_res >> 15) & 1) == 1;
                mc = m_c;
                pend = 1'b0;
            end
        end else if (cmd_valid) begin
            m_rd  = int'(cmd_rd);
            m_rs1 = int'(cmd_rs1);
            m_rs2 = int'(cmd_rs2);
            alu(int'(cmd_op), mrf[m_rs1], mrf[m_rs2], int'(cmd_imm), m_res, m_c);
            pend = 1'b1;
            wb_edge = cyc + 3;
            last_acc = cyc;
            acc_count++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            check("rst_rf_write", 32'(rf_write), 32'd0);
            check("rst_done_valid", 32'(done_valid), 32'd0);
            check("rst_rdaddr", {rf_rdAddrA, rf_rdAddrB}, 32'd0);
            check("rst_wraddr", 32'(rf_wrAddr), 32'd0);
            check("rst_wrdata", 32'(rf_wrData), 32'd0);
            check("rst_done_data", 32'(done_data), 32'd0);
`ifdef REGSEQ_FLAGS_EN
            check("rst_flags", {flag_z, flag_n, flag_c}, 32'd0);
`endif
        end else begin
            bit exp_wr;
            exp_wr = pend && (cyc == wb_edge - 1);
            if (rf_write) obs_wb_cyc = cyc;
            check("cmd_ready", 32'(cmd_ready), 32'(!pend));
            check("rf_write", 32'(rf_write), 32'(exp_wr));
            check("done_valid", 32'(done_valid), 32'(exp_wr));
            if (exp_wr) begin
                check("rf_wrAddr", 32'(rf_wrAddr), 32'(m_rd));
                check("rf_wrData", 32'(rf_wrData), 32'(m_res));
                check("done_data", 32'(done_data), 32'(m_res));
            end
            if (pend) begin
                check("rf_rdAddrA", 32'(rf_rdAddrA), 32'(m_rs1));
                check("rf_rdAddrB", 32'(rf_rdAddrB), 32'(m_rs2));
            end
`ifdef REGSEQ_FLAGS_EN
            check("flags", {flag_z, flag_n, flag_c}, {29'd0, mz, mn, mc});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                        input logic [15:0] imm, input bit keep = 1'b0);
        int start;
        bit got;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op  = op;
        cmd_rd  = rd[AW-1:0];
        cmd_rs1 = rs1[AW-1:0];
        cmd_rs2 = rs2[AW-1:0];
        cmd_imm = imm;
        start = acc_count;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (acc_count != start) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got none expected accept op %0d rd %0d", op, rd);
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int a;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: LI, latency and write-back cycle (WB is the cycle after edge accept+2)
        send(LI, 3, 0, 0, 16'h1234);
        wait_idle();
        check("t1_r3", 32'(rf[3]), 32'h1234);
        check("t1_wb_offset", 32'(obs_wb_cyc - last_acc), 32'd2);

        // 2: ADD with carry out
        send(LI, 1, 0, 0, 16'hFFFF);
        send(LI, 2, 0, 0, 16'h0002);
        send(ADD, 4, 1, 2, 16'h0);
        wait_idle();
        check("t2_r4", 32'(rf[4]), 32'h0001);
`ifdef REGSEQ_FLAGS_EN
        check("t2_flag_c", 32'(flag_c), 32'd1);
        check("t2_flag_z", 32'(flag_z), 32'd0);
`endif

        // 3: SUB with borrow, SLT signed cases
        send(LI, 1, 0, 0, 16'h0000);
        send(LI, 2, 0, 0, 16'h0001);
        send(SUB, 5, 1, 2, 16'h0);
        wait_idle();
        check("t3_r5", 32'(rf[5]), 32'hFFFF);
`ifdef REGSEQ_FLAGS_EN
        check("t3_flag_n", 32'(flag_n), 32'd1);
        check("t3_flag_c", 32'(flag_c), 32'd1);
`endif
        send(SLT, 6, 1, 2, 16'h0);
        send(LI, 1, 0, 0, 16'h8000);
        send(SLT, 10, 1, 2, 16'h0);
        send(SLT, 4, 2, 1, 16'h0);
        wait_idle();
        check("t3_slt_0_1", 32'(rf[6]), 32'd1);
        check("t3_slt_neg", 32'(rf[10]), 32'd1);
        check("t3_slt_rev", 32'(rf[4]), 32'd0);

        // 4: back-to-back with cmd_valid held high, RAW through r7
        send(LI, 7, 0, 0, 16'd5, 1'b1);
        a = last_acc;
        send(ADDI, 7, 7, 0, 16'd3);
        check("t4_accept_gap", 32'(last_acc - a), 32'd4);
        wait_idle();
        check("t4_r7", 32'(rf[7]), 32'd8);

        // 5: reset during EXEC aborts the write
        send(LI, 9, 0, 0, 16'h0AAA);
        send(ADD, 9, 7, 7, 16'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready", 32'(cmd_ready), 32'd1);
        wait_idle();
        check("t5_r9", 32'(rf[9]), 32'h0AAA);

        // 6: every op on r0 with rd=rs1=rs2
        send(LI, 0, 0, 0, 16'h00F0);
        send(AND_, 0, 0, 0, 16'h0);
        send(OR_, 0, 0, 0, 16'h0);
        wait_idle();
        check("t6_and_or", 32'(rf[0]), 32'h00F0);
        send(XOR_, 0, 0, 0, 16'h0);
        wait_idle();
        check("t6_xor", 32'(rf[0]), 32'h0000);
`ifdef REGSEQ_FLAGS_EN
        check("t6_xor_z", 32'(flag_z), 32'd1);
`endif
        send(LI, 0, 0, 0, 16'h00F0);
        send(SUB, 0, 0, 0, 16'h0);
        wait_idle();
        check("t6_sub", 32'(rf[0]), 32'h0000);
        send(LI, 0, 0, 0, 16'h00F0);
        send(ADD, 0, 0, 0, 16'h0);
        wait_idle();
        check("t6_add", 32'(rf[0]), 32'h01E0);
        send(SLT, 0, 0, 0, 16'h0);
        wait_idle();
        check("t6_slt", 32'(rf[0]), 32'h0000);
        send(LI, 0, 0, 0, 16'h00F0);
        send(ADDI, 0, 0, 0, 16'h0010);
        wait_idle();
        check("t6_addi", 32'(rf[0]), 32'h0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
